// File: rtl/tmr_core.sv
// ============================================================================
// Module      : tmr_core
// Description : Microsecond timer, timer side of the controller/timer handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmr_core #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        mode,
    input  logic [23:0] time_count,
    input  logic        clear,
    output logic        done
);

    localparam int TICKS_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int PRESC_W      = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

    localparam logic [PRESC_W-1:0] c_PRESC_MAX = PRESC_W'(TICKS_PER_US - 1);
    localparam logic [PRESC_W-1:0] c_PRESC_ONE = PRESC_W'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RUN     = 2'd1;
    localparam logic [1:0] c_EXPIRED = 2'd2;

    if ((CLK_FREQ_HZ < 1_000_000) || ((CLK_FREQ_HZ % 1_000_000) != 0)) begin : g_bad_clk_freq
        $error("tmr_core: CLK_FREQ_HZ must be a multiple of 1_000_000 and >= 1_000_000");
    end

    logic [1:0]         r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [23:0]        r_us_cnt;
    logic [23:0]        r_period;
    logic               r_mode;
    logic               r_done;

    logic w_tick;
    logic w_expire;

    assign w_tick   = (r_presc == c_PRESC_MAX);
    // Expiry lands on the tick that completes the last microsecond of the period.
    assign w_expire = w_tick && (r_us_cnt == (r_period - 24'd1));
    assign done     = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_presc  <= '0;
            r_us_cnt <= '0;
            r_period <= '0;
            r_mode   <= 1'b0;
            r_done   <= 1'b0;
        end else if (clear) begin
            r_state  <= c_IDLE;
            r_presc  <= '0;
            r_us_cnt <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (enable && (time_count != 24'd0)) begin
                        r_period <= time_count;
                        r_mode   <= mode;
                        r_presc  <= '0;
                        r_us_cnt <= '0;
                        r_state  <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (!enable) begin
                        r_state  <= c_IDLE;
                        r_presc  <= '0;
                        r_us_cnt <= '0;
                        r_done   <= 1'b0;
                    end else if (w_expire) begin
                        r_done <= 1'b1;
                        if (r_mode) begin
                            // Reload samples the inputs present on the expiry edge.
                            r_period <= time_count;
                            r_mode   <= mode;
                            r_presc  <= '0;
                            r_us_cnt <= '0;
                            if (time_count == 24'd0) begin
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_state <= c_EXPIRED;
                        end
                    end else begin
                        r_done <= 1'b0;
                        if (w_tick) begin
                            r_presc  <= '0;
                            r_us_cnt <= r_us_cnt + 24'd1;
                        end else begin
                            r_presc  <= r_presc + c_PRESC_ONE;
                        end
                    end
                end
                c_EXPIRED: begin
                    if (!enable) begin
                        r_state  <= c_IDLE;
                        r_presc  <= '0;
                        r_us_cnt <= '0;
                        r_done   <= 1'b0;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tmr_core.sv
// ============================================================================
// Module      : tb_tmr_core
// Description : Directed plus randomized check of tmr_core against a countdown model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmr_core;

    localparam int CLK_FREQ_HZ = 4_000_000;
    localparam int TPU         = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        mode;
    logic [23:0] time_count;
    logic        clear;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a timer armed with a number of clk edges left to expiry.
    bit m_active;
    bit m_expired;
    bit m_mode;
    int m_remaining;
    bit m_done;

    tmr_core #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .time_count (time_count),
        .clear      (clear),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active    = 1'b0;
        m_expired   = 1'b0;
        m_mode      = 1'b0;
        m_remaining = 0;
        m_done      = 1'b0;
    endtask

    task automatic model_step();
        if (clear) begin
            m_active  = 1'b0;
            m_expired = 1'b0;
            m_done    = 1'b0;
        end else if ((m_active || m_expired) && !enable) begin
            m_active  = 1'b0;
            m_expired = 1'b0;
            m_done    = 1'b0;
        end else if (m_expired) begin
            m_done = 1'b1;
        end else if (m_active) begin
            m_remaining--;
            m_done = 1'b0;
            if (m_remaining == 0) begin
                m_done = 1'b1;
                if (m_mode) begin
                    m_mode = mode;
                    if (time_count == 0) m_active = 1'b0;
                    else                 m_remaining = int'(time_count) * TPU;
                end else begin
                    m_active  = 1'b0;
                    m_expired = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (enable && time_count != 0) begin
                m_active    = 1'b1;
                m_mode      = mode;
                m_remaining = int'(time_count) * TPU;
            end
        end
    endtask

    // Inputs change on the falling edge; done is compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("done_vs_model", {31'd0, done}, {31'd0, m_done});
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (done !== 1'b1 && n < 5000);
    endtask

    task automatic idle_out(input int k);
        enable = 1'b0;
        clear  = 1'b0;
        repeat (k) cycle();
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        enable     = 1'b0;
        mode       = 1'b0;
        time_count = 24'd0;
        clear      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (2) cycle();

        // One-shot: 5 us -> 20 cycles, holds, cleared by a 1-cycle clear
        time_count = 24'd5; mode = 1'b0; enable = 1'b1;
        cycle();
        wait_done(n);
        chk("oneshot_latency", n, 32'd20);
        repeat (5) cycle();
        chk("oneshot_hold", {31'd0, done}, 32'd1);
        enable = 1'b0; clear = 1'b1;
        cycle();
        chk("clear_done", {31'd0, done}, 32'd0);
        idle_out(3);

        // Auto-reload: 3 us -> 12-cycle spacing, then period change to 2 us
        time_count = 24'd3; mode = 1'b1; enable = 1'b1;
        cycle();
        wait_done(n);
        chk("reload_first", n, 32'd12);
        cycle();
        chk("reload_pulse_width", {31'd0, done}, 32'd0);
        wait_done(n);
        chk("reload_gap1", n + 1, 32'd12);
        repeat (5) cycle();
        time_count = 24'd2;
        wait_done(n);
        chk("reload_gap_current", n + 5, 32'd12);
        wait_done(n);
        chk("reload_gap_new1", n, 32'd8);
        wait_done(n);
        chk("reload_gap_new2", n, 32'd8);
        idle_out(3);

        // Abort after 10 cycles, then a full re-run
        time_count = 24'd5; mode = 1'b0; enable = 1'b1;
        cycle();
        repeat (9) cycle();
        enable = 1'b0;
        repeat (30) cycle();
        chk("abort_no_done", {31'd0, done}, 32'd0);
        enable = 1'b1;
        cycle();
        wait_done(n);
        chk("rearm_latency", n, 32'd20);
        idle_out(3);

        // Boundaries
        time_count = 24'd0; enable = 1'b1;
        repeat (30) cycle();
        chk("zero_period_idle", {31'd0, done}, 32'd0);
        time_count = 24'd1;
        cycle();
        wait_done(n);
        chk("one_us_latency", n, 32'd4);
        idle_out(2);
        time_count = 24'd5; mode = 1'b0; enable = 1'b1;
        cycle();
        repeat (6) cycle();
        time_count = 24'd1; mode = 1'b1;
        wait_done(n);
        chk("oneshot_ignores_change", n + 6, 32'd20);
        repeat (3) cycle();
        chk("oneshot_mode_latched", {31'd0, done}, 32'd1);
        idle_out(2);
        time_count = 24'd300; mode = 1'b0; enable = 1'b1;
        cycle();
        wait_done(n);
        chk("wide_period_latency", n, 32'd1200);
        idle_out(2);

        // Clear on the expiry edge suppresses done
        time_count = 24'd2; mode = 1'b0; enable = 1'b1;
        cycle();
        repeat (7) cycle();
        clear = 1'b1;
        cycle();
        chk("clear_on_expiry", {31'd0, done}, 32'd0);
        idle_out(3);

        // Asynchronous reset while done is high
        time_count = 24'd1; enable = 1'b1;
        cycle();
        wait_done(n);
        @(posedge clk);
        model_step();
        #2 rst = 1'b1;
        #1 chk("async_rst_done", {31'd0, done}, 32'd0);
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cycle();
        time_count = 24'd5; enable = 1'b1;
        cycle();
        wait_done(n);
        chk("post_rst_latency", n, 32'd20);
        idle_out(3);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            enable = ($urandom_range(0, 29) != 0);
            clear  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) time_count = 24'($urandom_range(0, 4));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
